posicao_robo: RTL and testbench

- Position tracker directly downstream of the heading stage of the pipe-cleaner robot.
- Consumes the 3-bit heading code and a one-cycle "advance" command, and times a fixed-length motor step.
- Updates the robot's grid coordinates and reports completion, blocked moves at the grid edge, and a step count.
- Supplies position to the navigation/cleaning logic and tells the upstream controller when it may issue the next command.

---
 rtl/robo_pkg.sv | 16 +
 rtl/posicao_robo.sv | 150 +++++++++++++++
 tb/tb_posicao_robo.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/robo_pkg.sv
// Shared definitions for the pipe-cleaner robot: heading codes, motion FSM states, counter widths.
package robo_pkg;

  localparam logic [2:0] NORTE = 3'b001;
  localparam logic [2:0] OESTE = 3'b010;
  localparam logic [2:0] LESTE = 3'b011;
  localparam logic [2:0] SUL   = 3'b100;

  localparam int unsigned PassosW = 16;

  typedef enum logic [0:0] {
    PARADO,
    MOVENDO
  } estado_e;

endpackage

// File: rtl/posicao_robo.sv
// Grid position tracker: accepts one-step commands, times the motor step and updates (x, y).
// Rejects illegal headings and moves that would leave the grid before any motion starts.
module posicao_robo
  import robo_pkg::*;
#(
  parameter int unsigned GRID_W      = 16,
  parameter int unsigned GRID_H      = 16,
  parameter int unsigned COORD_W     = 4,
  parameter int unsigned MOVE_CYCLES = 4,
  parameter int unsigned START_X     = 0,
  parameter int unsigned START_Y     = 0
) (
  input  logic               clockc3,
  input  logic               reset,
  input  logic               avancar,
  input  logic [2:0]         orientacao,
  output logic [COORD_W-1:0] pos_x,
  output logic [COORD_W-1:0] pos_y,
  output logic               ocupado,
  output logic               movido,
  output logic               bloqueado,
  output logic               invalido,
  output logic [PassosW-1:0] passos
);

  localparam int unsigned CntW = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;
  localparam logic [CntW-1:0]    CntLoad = CntW'(MOVE_CYCLES - 1);
  localparam logic [COORD_W-1:0] XMax    = COORD_W'(GRID_W - 1);
  localparam logic [COORD_W-1:0] YMax    = COORD_W'(GRID_H - 1);
  localparam logic [COORD_W-1:0] XStart  = COORD_W'(START_X);
  localparam logic [COORD_W-1:0] YStart  = COORD_W'(START_Y);

  estado_e             state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [2:0]          dir_q, dir_d;
  logic [COORD_W-1:0]  pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [PassosW-1:0]  passos_q, passos_d;
  logic                ocupado_q, ocupado_d;
  logic                movido_q, movido_d;
  logic                bloqueado_q, bloqueado_d;
  logic                invalido_q, invalido_d;

  // alvo_valido: target cell and in-grid flag for the heading in effect this cycle
  logic [2:0]          dir_sel;
  logic                dir_legal, alvo_livre;
  logic [COORD_W-1:0]  alvo_x, alvo_y;

  assign dir_sel = (state_q == PARADO) ? orientacao : dir_q;

  always_comb begin
    dir_legal  = 1'b1;
    alvo_livre = 1'b0;
    alvo_x     = pos_x_q;
    alvo_y     = pos_y_q;
    case (dir_sel)
      NORTE: begin
        alvo_livre = (pos_y_q != YMax);
        alvo_y     = pos_y_q + COORD_W'(1);
      end
      SUL: begin
        alvo_livre = (pos_y_q != '0);
        alvo_y     = pos_y_q - COORD_W'(1);
      end
      LESTE: begin
        alvo_livre = (pos_x_q != XMax);
        alvo_x     = pos_x_q + COORD_W'(1);
      end
      OESTE: begin
        alvo_livre = (pos_x_q != '0);
        alvo_x     = pos_x_q - COORD_W'(1);
      end
      default: dir_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dir_d       = dir_q;
    pos_x_d     = pos_x_q;
    pos_y_d     = pos_y_q;
    passos_d    = passos_q;
    movido_d    = 1'b0;
    bloqueado_d = 1'b0;
    invalido_d  = 1'b0;
    unique case (state_q)
      PARADO: begin
        if (avancar) begin
          if (!dir_legal) begin
            invalido_d = 1'b1;
          end else if (!alvo_livre) begin
            bloqueado_d = 1'b1;
          end else begin
            dir_d   = orientacao;
            cnt_d   = CntLoad;
            state_d = MOVENDO;
          end
        end
      end
      MOVENDO: begin
        // avancar is deliberately ignored here, including on the completion edge
        if (cnt_q == '0) begin
          pos_x_d  = alvo_x;
          pos_y_d  = alvo_y;
          movido_d = 1'b1;
          if (passos_q != '1) passos_d = passos_q + PassosW'(1);
          state_d  = PARADO;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
    endcase
    ocupado_d = (state_d == MOVENDO);
  end

  always_ff @(posedge clockc3) begin
    if (reset) begin
      state_q     <= PARADO;
      cnt_q       <= '0;
      dir_q       <= '0;
      pos_x_q     <= XStart;
      pos_y_q     <= YStart;
      passos_q    <= '0;
      ocupado_q   <= 1'b0;
      movido_q    <= 1'b0;
      bloqueado_q <= 1'b0;
      invalido_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dir_q       <= dir_d;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      passos_q    <= passos_d;
      ocupado_q   <= ocupado_d;
      movido_q    <= movido_d;
      bloqueado_q <= bloqueado_d;
      invalido_q  <= invalido_d;
    end
  end

  assign pos_x     = pos_x_q;
  assign pos_y     = pos_y_q;
  assign passos    = passos_q;
  assign ocupado   = ocupado_q;
  assign movido    = movido_q;
  assign bloqueado = bloqueado_q;
  assign invalido  = invalido_q;

endmodule

// File: tb/tb_posicao_robo.sv
// Scoreboard bench for posicao_robo: stimulus queues expected pulses, a monitor checks them.
module tb_posicao_robo;
  import robo_pkg::*;

  localparam int unsigned MC = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        avancar;
  logic [2:0]  orientacao;
  logic [3:0]  pos_x, pos_y;
  logic        ocupado, movido, bloqueado, invalido;
  logic [15:0] passos;

  typedef struct packed {
    logic [1:0]  kind;  // 0 movido, 1 bloqueado, 2 invalido
    logic [3:0]  x;
    logic [3:0]  y;
    logic [15:0] p;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  passed = 0;

  posicao_robo #(
    .GRID_W(16), .GRID_H(16), .COORD_W(4), .MOVE_CYCLES(MC), .START_X(0), .START_Y(0)
  ) dut (
    .clockc3   (clk),
    .reset     (reset),
    .avancar   (avancar),
    .orientacao(orientacao),
    .pos_x     (pos_x),
    .pos_y     (pos_y),
    .ocupado   (ocupado),
    .movido    (movido),
    .bloqueado (bloqueado),
    .invalido  (invalido),
    .passos    (passos)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  task automatic push(input logic [1:0] k, input int x, input int y, input int p);
    ev_t e;
    e.kind = k; e.x = 4'(x); e.y = 4'(y); e.p = 16'(p);
    exp_q.push_back(e);
  endtask

  // Monitor: whenever a result pulse is visible, compare it with the oldest expectation
  always @(negedge clk) begin
    if (movido || bloqueado || invalido) begin
      ev_t a, e;
      a.kind = movido ? 2'd0 : (bloqueado ? 2'd1 : 2'd2);
      a.x = pos_x; a.y = pos_y; a.p = passos;
      check("pulse_exclusive", 32'(movido) + 32'(bloqueado) + 32'(invalido), 32'd1);
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_pulse: got kind=%0d pos=(%0d,%0d) passos=%0d, expected none",
                 a.kind, a.x, a.y, a.p);
      end else begin
        e = exp_q.pop_front();
        check("event", 32'(a), 32'(e));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Single-cycle avancar, then enough cycles for any step to finish
  task automatic cmd(input logic [2:0] d);
    @(negedge clk);
    orientacao = d; avancar = 1'b1;
    @(negedge clk);
    avancar = 1'b0;
    idle(MC + 2);
  endtask

  initial begin
    int busy;
    reset = 1'b1; avancar = 1'b1; orientacao = NORTE;
    idle(3);
    check("rst_pos_x", 32'(pos_x), 32'd0);
    check("rst_pos_y", 32'(pos_y), 32'd0);
    check("rst_passos", 32'(passos), 32'd0);
    check("rst_flags", {28'd0, ocupado, movido, bloqueado, invalido}, 32'd0);
    avancar = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    idle(2);

    push(2'd1, 0, 0, 0); cmd(SUL);
    push(2'd1, 0, 0, 0); cmd(OESTE);

    // First Norte: measure ocupado width
    push(2'd0, 0, 1, 1);
    @(negedge clk);
    orientacao = NORTE; avancar = 1'b1;
    busy = 0;
    @(negedge clk);
    avancar = 1'b0;
    repeat (MC + 4) begin
      if (ocupado) busy++;
      @(negedge clk);
    end
    check("ocupado_cycles", 32'(busy), 32'(MC));

    for (int i = 1; i <= 15; i++) begin
      push(2'd0, i, 1, 1 + i); cmd(LESTE);
    end
    push(2'd1, 15, 1, 16); cmd(LESTE);
    push(2'd0, 15, 2, 17); cmd(NORTE);

    // Requests during a step (mid-step and on the completion edge) are dropped
    push(2'd0, 15, 3, 18);
    @(negedge clk);
    orientacao = NORTE; avancar = 1'b1;
    @(negedge clk);
    avancar = 1'b0;
    @(negedge clk);
    orientacao = LESTE; avancar = 1'b1;
    @(negedge clk);
    avancar = 1'b0;
    @(negedge clk);
    avancar = 1'b1;
    @(negedge clk);
    avancar = 1'b0;
    idle(MC + 2);
    check("drop_pos_x", 32'(pos_x), 32'd15);

    push(2'd2, 15, 3, 18); cmd(3'b000);
    push(2'd2, 15, 3, 18); cmd(3'b111);

    // Reset on the 2nd cycle of a step aborts it without a movido pulse
    @(negedge clk);
    orientacao = SUL; avancar = 1'b1;
    @(negedge clk);
    avancar = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    idle(MC + 2);
    check("abort_pos_x", 32'(pos_x), 32'd0);
    check("abort_pos_y", 32'(pos_y), 32'd0);
    check("abort_passos", 32'(passos), 32'd0);
    check("abort_ocupado", 32'(ocupado), 32'd0);

    push(2'd0, 0, 1, 1); cmd(NORTE);

    idle(2);
    check("pending_events", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
